// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller: FSM state, return-stack frame
// and the default vector base address.
package irq_pkg;

    // Frame fields are sized for the widest supported configuration
    // (up to 256 sources, program addresses up to 16 bits).
    localparam int unsigned IRQ_IDX_W       = 8;
    localparam int unsigned IRQ_ADDR_W      = 16;
    localparam int unsigned IRQ_VECTOR_BASE = 32'h0000_00F0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAKE = 2'd1,
        RET  = 2'd2
    } irq_state_t;

    typedef struct packed {
        logic [IRQ_IDX_W-1:0]  idx;
        logic [IRQ_ADDR_W-1:0] addr;
    } irq_frame_t;

endpackage

// File: rtl/irq_return_stack.sv
// LIFO of {source index, return address} frames used for nested interrupts.
// The controller never pushes and pops in the same cycle.
module irq_return_stack
    import irq_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  irq_frame_t push_frame,
    output irq_frame_t top_frame,
    output logic       full,
    output logic       empty
);
    localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

    irq_frame_t       frames_q [STACK_DEPTH];
    irq_frame_t       frames_d [STACK_DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign full      = (count_q == CNT_W'(STACK_DEPTH));
    assign empty     = (count_q == '0);
    assign top_frame = empty ? '0 : frames_q[PTR_W'(count_q - CNT_W'(1))];

    always_comb begin
        frames_d = frames_q;
        count_d  = count_q;
        if (push && !full) begin
            frames_d[PTR_W'(count_q)] = push_frame;
            count_d                   = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                frames_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            frames_q <= frames_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Vectored, prioritised interrupt controller: edge-latched requests, mask/GIE
// arbitration, vector take at instruction boundaries and LIFO return on RETI.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned prog_mem_length = 8,
    parameter int unsigned NUM_IRQ         = 4,
    parameter int unsigned VECTOR_BASE     = IRQ_VECTOR_BASE,
    parameter int unsigned STACK_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IRQ-1:0]         irqIn,
    input  logic                       ceMask,
    input  logic [NUM_IRQ-1:0]         maskIn,
    input  logic                       eiCmd,
    input  logic                       diCmd,
    input  logic                       instrDone,
    input  logic [prog_mem_length-1:0] pcNext,
    input  logic                       retiCmd,
    output logic                       irqTake,
    output logic [prog_mem_length-1:0] vectorAdr,
    output logic                       retValid,
    output logic [prog_mem_length-1:0] retAdr,
    output logic [NUM_IRQ-1:0]         pending,
    output logic [NUM_IRQ-1:0]         active,
    output logic                       stackErr
);
    localparam int unsigned WIN_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0]         sync1_q, sync2_q, edge_q;
    logic [NUM_IRQ-1:0]         rise;
    logic [NUM_IRQ-1:0]         pending_q, pending_d;
    logic [NUM_IRQ-1:0]         active_q, active_d;
    logic [NUM_IRQ-1:0]         mask_q, mask_d;
    logic                       gie_q, gie_d;
    logic                       stack_err_q, stack_err_d;
    irq_state_t                 state_q, state_d;
    logic [prog_mem_length-1:0] vector_q, vector_d;
    logic [prog_mem_length-1:0] ret_adr_q, ret_adr_d;

    logic [NUM_IRQ-1:0]         eligible, win_onehot, take_set, ret_clr;
    logic [WIN_W-1:0]           winner;
    logic                       prio_blk, win_found;

    logic                       stk_push, stk_pop, stk_full, stk_empty;
    irq_frame_t                 push_frame, top_frame;

    irq_return_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_frame(push_frame),
        .top_frame (top_frame),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign push_frame = {IRQ_IDX_W'(winner), IRQ_ADDR_W'(pcNext)};

    // A source may only preempt if its index is below every active index.
    always_comb begin
        eligible   = '0;
        win_onehot = '0;
        winner     = '0;
        prio_blk   = 1'b0;
        win_found  = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            prio_blk    = prio_blk | active_q[i];
            eligible[i] = pending_q[i] & mask_q[i] & gie_q & ~stk_full & ~prio_blk;
            if (eligible[i] && !win_found) begin
                win_found     = 1'b1;
                winner        = WIN_W'(i);
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        take_set    = '0;
        ret_clr     = '0;
        stack_err_d = stack_err_q;
        vector_d    = vector_q;
        ret_adr_d   = ret_adr_q;
        case (state_q)
            IDLE: begin
                if (retiCmd) begin
                    if (!stk_empty) begin
                        stk_pop   = 1'b1;
                        state_d   = RET;
                        ret_adr_d = prog_mem_length'(top_frame.addr);
                        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                            ret_clr[i] = (IRQ_IDX_W'(i) == top_frame.idx);
                        end
                    end else begin
                        stack_err_d = 1'b1;
                    end
                end else if (instrDone && |eligible) begin
                    stk_push = 1'b1;
                    state_d  = TAKE;
                    take_set = win_onehot;
                    vector_d = prog_mem_length'(VECTOR_BASE + 32'(winner));
                end
            end
            TAKE:    state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d = ceMask ? maskIn : mask_q;
        gie_d  = gie_q;
        if (diCmd) begin
            gie_d = 1'b0;
        end else if (eiCmd) begin
            gie_d = 1'b1;
        end
        rise      = sync2_q & ~edge_q;
        pending_d = (pending_q & ~take_set) | rise;
        active_d  = (active_q | take_set) & ~ret_clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            edge_q      <= '0;
            pending_q   <= '0;
            active_q    <= '0;
            mask_q      <= '0;
            gie_q       <= 1'b0;
            stack_err_q <= 1'b0;
            state_q     <= IDLE;
            vector_q    <= '0;
            ret_adr_q   <= '0;
        end else begin
            sync1_q     <= irqIn;
            sync2_q     <= sync1_q;
            edge_q      <= sync2_q;
            pending_q   <= pending_d;
            active_q    <= active_d;
            mask_q      <= mask_d;
            gie_q       <= gie_d;
            stack_err_q <= stack_err_d;
            state_q     <= state_d;
            vector_q    <= vector_d;
            ret_adr_q   <= ret_adr_d;
        end
    end

    assign irqTake   = (state_q == TAKE);
    assign retValid  = (state_q == RET);
    assign vectorAdr = vector_q;
    assign retAdr    = ret_adr_q;
    assign pending   = pending_q;
    assign active    = active_q;
    assign stackErr  = stack_err_q;

endmodule
